// File: rtl/gerador_sel_img.sv
// rtl/gerador_sel_img.sv - image select sequencer: dwell rotation over active flags with fault alarm pre-emption
module gerador_sel_img #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] status_in,
    input  logic       skip,
    output logic [2:0] S,
    output logic [5:0] I,
    output logic       valid,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [2:0]       S_BLANK  = 3'd7;
    localparam logic [2:0]       S_FAULT  = 3'd5;

    state_t           state;
    logic [5:0]       flags_q;
    logic [CNT_W-1:0] cnt;

    // First set flag scanning cur+1 .. cur+6 (mod 6); returns cur when cur is the only set bit.
    function automatic logic [2:0] next_idx(input logic [5:0] f, input logic [2:0] cur);
        logic [2:0] r;
        logic [3:0] idx;
        r = cur;
        for (int k = 6; k >= 1; k--) begin
            idx = {1'b0, cur} + 4'(k);
            if (idx >= 4'd6) idx = idx - 4'd6;
            if (f[idx[2:0]]) r = idx[2:0];
        end
        return r;
    endfunction

    // Lowest set flag among images 0..4; the fault image is handled by ALARM.
    function automatic logic [2:0] lowest_idx(input logic [4:0] f);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (f[k]) r = 3'(k);
        end
        return r;
    endfunction

    assign I = flags_q;

    // Input stage: register raw status flags every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) flags_q <= 6'b0;
        else       flags_q <= status_in;
    end

    // Sequencer FSM with registered S / valid / wrap and dwell counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            S     <= S_BLANK;
            valid <= 1'b0;
            wrap  <= 1'b0;
            cnt   <= '0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (flags_q[5]) begin
                        state <= ALARM;
                        S     <= S_FAULT;
                        valid <= 1'b1;
                    end else if (flags_q != 6'b0) begin
                        state <= SHOW;
                        S     <= lowest_idx(flags_q[4:0]);
                        valid <= 1'b1;
                    end else begin
                        S     <= S_BLANK;
                        valid <= 1'b0;
                    end
                end
                SHOW: begin
                    if (flags_q[5] && S != S_FAULT) begin
                        state <= ALARM;
                        S     <= S_FAULT;
                        cnt   <= '0;
                    end else if (flags_q == 6'b0) begin
                        state <= IDLE;
                        S     <= S_BLANK;
                        valid <= 1'b0;
                        cnt   <= '0;
                    end else if (!flags_q[S] || skip || cnt == CNT_LAST) begin
                        // A simultaneous skip and dwell expiry collapse into one advance here.
                        S    <= next_idx(flags_q, S);
                        wrap <= (next_idx(flags_q, S) <= S);
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ALARM: begin
                    cnt <= '0;
                    if (!flags_q[5]) begin
                        if (flags_q == 6'b0) begin
                            state <= IDLE;
                            S     <= S_BLANK;
                            valid <= 1'b0;
                        end else begin
                            state <= SHOW;
                            S     <= lowest_idx(flags_q[4:0]);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    S     <= S_BLANK;
                    valid <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gerador_sel_img.sv
// tb/tb_gerador_sel_img.sv - scoreboard bench for gerador_sel_img with behavioural reference model
module tb_gerador_sel_img;

    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] status_in;
    logic       skip;
    logic [2:0] S;
    logic [5:0] I;
    logic       valid;
    logic       wrap;

    gerador_sel_img #(.DWELL_CYCLES(DW), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .status_in(status_in), .skip(skip),
        .S(S), .I(I), .valid(valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] exp_q[$];
    bit          done  = 0;

    // Reference model: mode 0 = blank, 1 = rotating, 2 = fault shown.
    int         m_mode;
    int         m_img;
    int         m_el;
    logic [5:0] m_f;
    bit         m_wrap;

    function automatic int first_from(input logic [5:0] f, input int start, input int span);
        for (int k = 0; k < span; k++)
            if (f[(start + k) % 6]) return (start + k) % 6;
        return -1;
    endfunction

    function automatic logic [10:0] model_out();
        logic [2:0] s;
        s = (m_mode == 0) ? 3'd7 : (m_mode == 2) ? 3'd5 : 3'(m_img);
        return {s, (m_mode != 0), m_wrap, m_f};
    endfunction

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got S=%0d valid=%0b wrap=%0b I=%b, expected S=%0d valid=%0b wrap=%0b I=%b",
                     name, got[10:8], got[7], got[6], got[5:0], expv[10:8], expv[7], expv[6], expv[5:0]);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_img = 0; m_el = 0; m_f = 6'b0; m_wrap = 0;
    endtask

    task automatic model_step(input logic [5:0] st, input bit sk);
        int n;
        m_wrap = 0;
        if (m_mode == 0) begin
            if (m_f[5]) m_mode = 2;
            else if (m_f != 0) begin m_mode = 1; m_img = first_from(m_f, 0, 6); m_el = 0; end
        end else if (m_mode == 1) begin
            if (m_f[5] && m_img != 5) begin m_mode = 2; m_el = 0; end
            else if (m_f == 0) m_mode = 0;
            else if (!m_f[m_img] || sk || m_el == DW - 1) begin
                n = first_from(m_f, m_img + 1, 6);
                m_wrap = (n <= m_img);
                m_img = n;
                m_el = 0;
            end else m_el++;
        end else begin
            if (!m_f[5]) begin
                if (m_f == 0) m_mode = 0;
                else begin m_mode = 1; m_img = first_from(m_f, 0, 5); m_el = 0; end
            end
        end
        m_f = st;
    endtask

    task automatic cyc(input logic [5:0] st, input bit sk);
        @(negedge clk);
        reset = 1'b0; status_in = st; skip = sk;
        model_step(st, sk);
        exp_q.push_back(model_out());
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1 chk("reset_immediate", {S, valid, wrap, I}, model_out());
        exp_q.push_back(model_out());
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            status_in = 6'($urandom_range(0, 63));
            skip = 1'($urandom_range(0, 1));
            exp_q.push_back(model_out());
        end
    endtask

    task automatic run(input logic [5:0] st, input int n);
        for (int k = 0; k < n; k++) cyc(st, 1'b0);
    endtask

    // Stimulus: directed scenarios, then randomized traffic with occasional resets.
    initial begin
        logic [5:0] cur;
        reset = 1'b1; status_in = 6'b0; skip = 1'b0;
        model_reset();
        do_reset(2);
        run(6'b000101, 12);
        run(6'b000100, 14);
        run(6'b000000, 3);
        run(6'b000100, 6);
        do_reset(3);
        run(6'b001010, 3);
        cyc(6'b001010, 1'b1);
        run(6'b001010, 3);
        cyc(6'b001010, 1'b1);
        run(6'b001010, 4);
        run(6'b101010, 3);
        cyc(6'b101010, 1'b1);
        run(6'b101010, 10);
        run(6'b000010, 4);
        run(6'b001001, 5);
        run(6'b000001, 4);
        cur = 6'b0;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                cur = 6'($urandom_range(0, 31));
                if ($urandom_range(0, 3) == 0) cur[5] = 1'b1;
            end
            if ($urandom_range(0, 499) == 0) do_reset(int'($urandom_range(1, 3)));
            else cyc(cur, ($urandom_range(0, 5) == 0));
        end
        @(negedge clk);
        done = 1;
    end

    // Monitor: pop one expected response per clock and compare against DUT outputs.
    initial begin
        logic [10:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cycle_outputs", {S, valid, wrap, I}, e);
            end
            if (done && exp_q.size() == 0) break;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
